// File: rtl/pio_pkg.sv
// Shared constants, FIFO entry layout and sizing helper for the PIO capture receiver.
// Optional timestamp field is compiled in when PIO_CAPTURE_TSTAMP_EN is defined.
package pio_pkg;

    localparam int PIO_WIDTH      = 8;
    localparam int DEF_STABLE_CYC = 3;
    localparam int DEF_FIFO_DEPTH = 4;

`ifdef PIO_CAPTURE_TSTAMP_EN
    localparam int TSTAMP_W = 16;

    typedef struct packed {
        logic [PIO_WIDTH-1:0] data;
        logic [TSTAMP_W-1:0]  tstamp;
    } pio_entry_t;
`else
    typedef struct packed {
        logic [PIO_WIDTH-1:0] data;
    } pio_entry_t;
`endif

    // Entry count needs one bit more than the pointer to represent "full".
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pio_sync_fifo.sv
// Single-clock FIFO with a registered head word that falls through on the first push.
// Reports a drop when a push meets a full FIFO without a simultaneous pop.
module pio_sync_fifo
    import pio_pkg::*;
#(
    parameter int DW    = PIO_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DW-1:0]         din,
    input  logic                  pop,
    output logic [DW-1:0]         dout,
    output logic                  empty,
    output logic                  full,
    output logic [$clog2(DEPTH):0] level,
    output logic                  drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] rd_ptr_nxt;
    logic [LW-1:0] level_q, level_d;
    logic [DW-1:0] head_q, head_d;
    logic          push_ok;
    logic          pop_ok;

    assign empty      = (level_q == '0);
    assign full       = (level_q == LW'(DEPTH));
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);
    assign pop_ok     = pop && !empty;
    assign push_ok    = push && (!full || pop_ok);
    assign drop       = push && !push_ok;
    assign dout       = head_q;
    assign level      = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_nxt;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Head reloads from the incoming word when it would otherwise be the only entry.
        if (empty) begin
            if (push_ok) begin
                head_d = din;
            end
        end else if (pop_ok) begin
            if (level_q == LW'(1)) begin
                if (push_ok) begin
                    head_d = din;
                end
            end else begin
                head_d = mem_q[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/pio_capture_rx.sv
// Synchronizes the parallel PIO bus, qualifies stable new words and queues them for a valid/ready consumer.
// Define PIO_CAPTURE_TSTAMP_EN to attach a 16-bit cycle timestamp (out_tstamp) to every captured word.
module pio_capture_rx
    import pio_pkg::*;
#(
    parameter int WIDTH      = PIO_WIDTH,
    parameter int STABLE_CYC = DEF_STABLE_CYC,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 pio_in,
    input  logic                             pio_en,
    output logic [WIDTH-1:0]                 out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [lvl_w(FIFO_DEPTH)-1:0]     fifo_level,
    output logic                             overflow,
    input  logic                             ovf_clr
`ifdef PIO_CAPTURE_TSTAMP_EN
    ,
    output logic [15:0]                      out_tstamp
`endif
);

    localparam logic [3:0] STAB_LAST = 4'(STABLE_CYC - 1);

`ifdef PIO_CAPTURE_TSTAMP_EN
    localparam int ENTRY_W = WIDTH + TSTAMP_W;
`else
    localparam int ENTRY_W = WIDTH;
`endif

    logic [WIDTH-1:0]   sync1_q;
    logic [WIDTH-1:0]   sync2_q;
    logic [WIDTH-1:0]   prev_q;
    logic [WIDTH-1:0]   last_acc_q, last_acc_d;
    logic [3:0]         stab_cnt_q, stab_cnt_d;
    logic               overflow_q, overflow_d;
    logic               accept;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_drop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // A fresh accept fires on the edge that would bring the count up to STABLE_CYC.
    always_comb begin
        stab_cnt_d = '0;
        accept     = 1'b0;
        if (pio_en && (sync2_q != last_acc_q) && (sync2_q == prev_q)) begin
            if (stab_cnt_q == STAB_LAST) begin
                accept = 1'b1;
            end else begin
                stab_cnt_d = stab_cnt_q + 4'd1;
            end
        end
    end

    assign last_acc_d = accept ? sync2_q : last_acc_q;
    assign overflow_d = fifo_drop | (overflow_q & ~ovf_clr);
    assign pop        = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            last_acc_q <= '0;
            stab_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= pio_in;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            last_acc_q <= last_acc_d;
            stab_cnt_q <= stab_cnt_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef PIO_CAPTURE_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tstamp_q <= '0;
        end else begin
            tstamp_q <= tstamp_q + TSTAMP_W'(1);
        end
    end

    assign wr_entry   = {sync2_q, tstamp_q};
    assign out_data   = rd_entry[ENTRY_W-1 -: WIDTH];
    assign out_tstamp = rd_entry[TSTAMP_W-1:0];
`else
    assign wr_entry = sync2_q;
    assign out_data = rd_entry;
`endif

    pio_sync_fifo #(
        .DW    (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (rd_entry),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level),
        .drop  (fifo_drop)
    );

    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pio_capture_rx.sv
// Directed table-driven bench for pio_capture_rx with hand-computed expectations.
module tb_pio_capture_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pio_in = '0;
    logic       pio_en = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       ovf_clr = 1'b0;
`ifdef PIO_CAPTURE_TSTAMP_EN
    logic [15:0] out_tstamp;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pio_capture_rx dut (
        .clk        (clk),
        .rst        (rst),
        .pio_in     (pio_in),
        .pio_en     (pio_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
`ifdef PIO_CAPTURE_TSTAMP_EN
        ,
        .out_tstamp (out_tstamp)
`endif
    );

    typedef struct {
        logic [7:0] pio;
        logic       en;
        logic       rdy;
        logic       clr;
        int         ticks;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] el;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] pio, input logic en, input logic rdy, input logic clr,
                       input int ticks, input logic ev, input logic [7:0] ed,
                       input logic [2:0] el, input logic eo);
        vec_t v;
        v.pio = pio; v.en = en; v.rdy = rdy; v.clr = clr; v.ticks = ticks;
        v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
        vecs.push_back(v);
    endtask

    initial begin
        //   pio    en    rdy   clr  ticks ev    data   lvl   ovf
        add(8'h3C, 1'b1, 1'b0, 1'b0, 2,  1'b0, 8'h00, 3'd0, 1'b0);  // glitch
        add(8'h00, 1'b1, 1'b0, 1'b0, 8,  1'b0, 8'h00, 3'd0, 1'b0);
        add(8'hA5, 1'b1, 1'b0, 1'b0, 5,  1'b0, 8'h00, 3'd0, 1'b0);  // latency
        add(8'hA5, 1'b1, 1'b0, 1'b0, 1,  1'b1, 8'hA5, 3'd1, 1'b0);
        add(8'hA5, 1'b1, 1'b1, 1'b0, 1,  1'b0, 8'h00, 3'd0, 1'b0);
        add(8'h01, 1'b1, 1'b0, 1'b0, 6,  1'b1, 8'h01, 3'd1, 1'b0);  // fill
        add(8'h02, 1'b1, 1'b0, 1'b0, 6,  1'b1, 8'h01, 3'd2, 1'b0);
        add(8'h03, 1'b1, 1'b0, 1'b0, 6,  1'b1, 8'h01, 3'd3, 1'b0);
        add(8'h04, 1'b1, 1'b0, 1'b0, 6,  1'b1, 8'h01, 3'd4, 1'b0);
        add(8'h05, 1'b1, 1'b0, 1'b0, 6,  1'b1, 8'h01, 3'd4, 1'b1);  // dropped
        add(8'h05, 1'b1, 1'b0, 1'b0, 2,  1'b1, 8'h01, 3'd4, 1'b1);
        add(8'h05, 1'b1, 1'b0, 1'b1, 1,  1'b1, 8'h01, 3'd4, 1'b0);  // clear
        add(8'h06, 1'b1, 1'b0, 1'b0, 5,  1'b1, 8'h01, 3'd4, 1'b0);
        add(8'h06, 1'b1, 1'b1, 1'b0, 1,  1'b1, 8'h02, 3'd4, 1'b0);  // push+pop while full
        add(8'h06, 1'b1, 1'b1, 1'b0, 1,  1'b1, 8'h03, 3'd3, 1'b0);
        add(8'h06, 1'b1, 1'b1, 1'b0, 1,  1'b1, 8'h04, 3'd2, 1'b0);
        add(8'h06, 1'b1, 1'b1, 1'b0, 1,  1'b1, 8'h06, 3'd1, 1'b0);
        add(8'h06, 1'b1, 1'b1, 1'b0, 1,  1'b0, 8'h00, 3'd0, 1'b0);
        add(8'h77, 1'b0, 1'b0, 1'b0, 20, 1'b0, 8'h00, 3'd0, 1'b0);  // disabled
        add(8'h77, 1'b1, 1'b0, 1'b0, 2,  1'b0, 8'h00, 3'd0, 1'b0);
        add(8'h77, 1'b1, 1'b0, 1'b0, 1,  1'b1, 8'h77, 3'd1, 1'b0);
        add(8'h11, 1'b1, 1'b0, 1'b0, 6,  1'b1, 8'h77, 3'd2, 1'b0);
        add(8'h22, 1'b1, 1'b0, 1'b0, 4,  1'b1, 8'h77, 3'd2, 1'b0);  // mid-qualification

        tick();
        tick();
        rst = 1'b0;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'h00);
        chk("reset fifo_level", 32'(fifo_level), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);

        foreach (vecs[i]) begin
            pio_in    = vecs[i].pio;
            pio_en    = vecs[i].en;
            out_ready = vecs[i].rdy;
            ovf_clr   = vecs[i].clr;
            repeat (vecs[i].ticks) tick();
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("row%0d fifo_level", i), 32'(fifo_level), 32'(vecs[i].el));
            chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(vecs[i].eo));
            if (vecs[i].ev) begin
                chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(vecs[i].ed));
            end
            $display("row %0d: pio=%02h en=%0b rdy=%0b clr=%0b -> valid=%0b data=%02h level=%0d ovf=%0b",
                     i, vecs[i].pio, vecs[i].en, vecs[i].rdy, vecs[i].clr,
                     out_valid, out_data, fifo_level, overflow);
        end
        ovf_clr   = 1'b0;
        out_ready = 1'b0;

        // Asynchronous reset between clock edges with two words queued.
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst fifo_level", 32'(fifo_level), 32'd0);
        chk("async rst overflow", 32'(overflow), 32'd0);
        chk("async rst out_data", 32'(out_data), 32'h00);
        $display("async reset: valid=%0b level=%0d ovf=%0b", out_valid, fifo_level, overflow);
        tick();
        rst = 1'b0;

        // pio_in still 0x22: the bus is recaptured with full latency after reset release.
        repeat (5) tick();
        chk("post-rst early valid", 32'(out_valid), 32'd0);
        tick();
        chk("post-rst valid", 32'(out_valid), 32'd1);
        chk("post-rst data", 32'(out_data), 32'h22);
        chk("post-rst level", 32'(fifo_level), 32'd1);
`ifdef PIO_CAPTURE_TSTAMP_EN
        chk("post-rst tstamp", 32'(out_tstamp), 32'd5);
`endif
        $display("post-reset capture: valid=%0b data=%02h level=%0d", out_valid, out_data, fifo_level);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pio_capture_rx.md
Name: pio_capture_rx

Overview:
- Receive-side reader for the 8-bit parallel FPGA PIO bus that our flop blocks drive.
- Synchronizes the bus into `clk`, qualifies each new word by requiring it to be stable and enabled, and buffers accepted words in a small FIFO.
- Delivers words downstream on a valid/ready handshake.
- Sits at the board-facing edge, feeding the on-chip control/status logic.

Parameters:
- WIDTH, 8, PIO bus width in bits.
- STABLE_CYC, 3, consecutive synchronized cycles a new value must hold before acceptance (legal range 1..15).
- FIFO_DEPTH, 4, capture FIFO entries (power of two, at least 2).

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- pio_in  input  WIDTH  asynchronous parallel PIO bus from the far end.
- pio_en  input  1  capture enable; synchronous to clk.
- out_data  output  WIDTH  head-of-FIFO word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count.
- overflow  output  1  sticky: an accepted word was dropped because the FIFO was full.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (async, rst=1):
  - sync stages = 0; last_acc = 0; stab_cnt = 0.
  - FIFO pointers = 0; out_valid = 0; out_data = 0; fifo_level = 0; overflow = 0.
- Synchronizer:
  - Two-flop sync on pio_in (sync1 -> sync2).
  - Only sync2 is used downstream.
- Stability counter (4 bits, saturating at STABLE_CYC):
  - If sync2 != last_acc and sync2 == previous sync2: increment.
  - Otherwise: reset to 0.
- Accept:
  - Condition: pio_en=1 and stab_cnt reaches STABLE_CYC in a cycle.
  - Effects: last_acc <= sync2, push sync2, stab_cnt <= 0.
  - A value equal to last_acc is never re-accepted; consequently 0 is not captured after reset until some non-zero word has been accepted.
- pio_en=0:
  - stab_cnt held at 0; no pushes.
  - FIFO continues to drain.
  - Re-enabling restarts qualification from 0.
- Latency:
  - Change on pio_in set up before edge 1 -> out_valid high after edge STABLE_CYC+3.
  - Default: 6 clocks.
  - Applies only if the FIFO was empty and pio_en held 1.
- FIFO:
  - out_data is registered head; first-word fall-through (no extra read cycle).
  - Pop on out_valid && out_ready.
  - Push when full:
    - With a simultaneous pop: succeeds; level unchanged.
    - Otherwise: word dropped and overflow <= 1.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH; level tracks push-pop.
- overflow:
  - Set has priority over ovf_clr in the same cycle.
  - Remains set until ovf_clr is sampled high with no new drop.
- Reset mid-operation: all state returns to reset values immediately (async); in-flight qualification and FIFO contents are discarded.
- pio_in glitch shorter than STABLE_CYC synced cycles: never captured.

Optional Feature:
- PIO_CAPTURE_TSTAMP_EN defined:
  - Adds output out_tstamp [15:0].
  - A free-running 16-bit cycle counter (reset 0, wraps at 0xFFFF->0) is sampled on each accept and stored alongside the word in the FIFO.
  - out_tstamp tracks out_data.
- Not defined: port and counter absent; FIFO stores WIDTH bits only.

Decomposition:
- Package pio_pkg:
  - PIO_WIDTH default (8).
  - Default STABLE_CYC and FIFO_DEPTH constants.
  - Typedef for the FIFO entry struct (data, plus tstamp under the macro).
  - Level-width helper function.
- Sub-module pio_sync_fifo:
  - Generic synchronous FIFO with push/pop/full/empty/level.
  - Instantiated once.
  - The synchronizer and qualifier stay in the top module.

Test Plan:
- Reset, pio_en=1, pio_in=0xA5 held -> out_valid rises 6 clocks later with out_data=0xA5 and fifo_level=1; pop clears it.
- Glitch pio_in 0x00->0x3C for 2 clocks then back -> no word pushed; fifo_level stays 0.
- out_ready=0, present 5 distinct stable words 0x01..0x05 -> first 4 buffered (level=4), 5th dropped, overflow=1; ovf_clr pulse -> overflow=0.
- FIFO full with out_ready=1 in the same cycle a 6th word is accepted -> no drop, level stays 4, overflow stays 0, order preserved.
- pio_en=0 while pio_in=0x77 stable for 20 clocks -> nothing captured; pio_en=1 -> word 0x77 appears 3 clocks after enable (STABLE_CYC qualification restart).
- Assert rst mid-qualification with 2 words queued -> out_valid=0, fifo_level=0, overflow=0 immediately; with PIO_CAPTURE_TSTAMP_EN, first post-reset capture carries a timestamp equal to the accept-cycle count since reset release.
